wb_register_file: RTL and testbench

Writeback-side consumer of the MEM/WB pipeline register: decodes the destination register from the retiring instruction and commits the writeback data into a 32-entry integer register file. Also serves the decode-stage operand reads and keeps a retired-instruction counter. Sits between the MEM/WB register outputs and the ID stage. x0 is hardwired to zero. Same-cycle writeback is bypassed to both read ports, so the pipeline needs no WB→ID hazard stall.

---
 rtl/wb_register_file.sv | 87 ++++++++
 tb/tb_wb_register_file.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/wb_register_file.sv
// Writeback stage: commits MEM/WB results into a 32-entry register file, serves
// two combinational ID-stage read ports with same-cycle bypass, counts retirements.
module wb_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           instruction_WB_in,
  input  logic [DATA_WIDTH-1:0] wb_data_in,
  input  logic                  RegWEn_WB_in,
  input  logic [4:0]            rs1_addr_in,
  input  logic [4:0]            rs2_addr_in,
  output logic [DATA_WIDTH-1:0] rs1_data_out,
  output logic [DATA_WIDTH-1:0] rs2_data_out,
  output logic [CNT_WIDTH-1:0]  instret_out,
  output logic                  last_we_out,
  output logic [4:0]            last_rd_out,
  output logic [DATA_WIDTH-1:0] last_wdata_out
);

  logic [4:0]            rd;
  logic                  commit;
  logic                  retire;
  logic [DATA_WIDTH-1:0] regs [32];
  logic [4:0]            raddr [2];
  logic [DATA_WIDTH-1:0] rdata [2];

  logic [CNT_WIDTH-1:0]  instret_reg;
  logic                  last_we_reg;
  logic [4:0]            last_rd_reg;
  logic [DATA_WIDTH-1:0] last_wdata_reg;

  assign rd     = instruction_WB_in[11:7];
  // Writes to x0 are not commits; reset suppresses both the write and the bypass.
  assign commit = RegWEn_WB_in && (rd != 5'd0) && !reset;
  assign retire = (instruction_WB_in != 32'h0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[rd] <= wb_data_in;
    end
  end

  assign raddr[0] = rs1_addr_in;
  assign raddr[1] = rs2_addr_in;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_read
      assign rdata[gi] = (raddr[gi] == 5'd0)             ? '0 :
                         (commit && (rd == raddr[gi]))   ? wb_data_in :
                                                           regs[raddr[gi]];
    end
  endgenerate

  assign rs1_data_out = rdata[0];
  assign rs2_data_out = rdata[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      instret_reg    <= '0;
      last_we_reg    <= 1'b0;
      last_rd_reg    <= 5'd0;
      last_wdata_reg <= '0;
    end else begin
      if (retire) begin
        instret_reg <= instret_reg + CNT_WIDTH'(1);
      end
      last_we_reg <= commit;
      if (commit) begin
        last_rd_reg    <= rd;
        last_wdata_reg <= wb_data_in;
      end
    end
  end

  assign instret_out    = instret_reg;
  assign last_we_out    = last_we_reg;
  assign last_rd_out    = last_rd_reg;
  assign last_wdata_out = last_wdata_reg;

endmodule

// File: tb/tb_wb_register_file.sv
// Scoreboard bench: driver pushes per-cycle expectations from an array model,
// a negedge monitor pops and compares; a 4-bit-counter instance checks wrap.
module tb_wb_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction_WB_in;
  logic [31:0] wb_data_in;
  logic        RegWEn_WB_in;
  logic [4:0]  rs1_addr_in;
  logic [4:0]  rs2_addr_in;

  logic [31:0] rs1_data_out, rs2_data_out, last_wdata_out;
  logic [63:0] instret_out;
  logic        last_we_out;
  logic [4:0]  last_rd_out;

  logic [31:0] s_rs1, s_rs2, s_wdata;
  logic [3:0]  s_instret;
  logic        s_we;
  logic [4:0]  s_rd;

  always #5 clk = ~clk;

  wb_register_file #(.DATA_WIDTH(32), .CNT_WIDTH(64)) dut (
    .clk(clk), .reset(reset), .instruction_WB_in(instruction_WB_in),
    .wb_data_in(wb_data_in), .RegWEn_WB_in(RegWEn_WB_in),
    .rs1_addr_in(rs1_addr_in), .rs2_addr_in(rs2_addr_in),
    .rs1_data_out(rs1_data_out), .rs2_data_out(rs2_data_out),
    .instret_out(instret_out), .last_we_out(last_we_out),
    .last_rd_out(last_rd_out), .last_wdata_out(last_wdata_out)
  );

  wb_register_file #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut_small (
    .clk(clk), .reset(reset), .instruction_WB_in(instruction_WB_in),
    .wb_data_in(wb_data_in), .RegWEn_WB_in(RegWEn_WB_in),
    .rs1_addr_in(rs1_addr_in), .rs2_addr_in(rs2_addr_in),
    .rs1_data_out(s_rs1), .rs2_data_out(s_rs2),
    .instret_out(s_instret), .last_we_out(s_we),
    .last_rd_out(s_rd), .last_wdata_out(s_wdata)
  );

  typedef struct {
    logic        chk;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [63:0] instret;
    logic [3:0]  instret4;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: architectural state after all edges seen so far
  logic [31:0] m_regs [32];
  logic [63:0] m_cnt;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.chk) begin
        compare("rs1_data", 64'(rs1_data_out), 64'(e.rs1));
        compare("rs2_data", 64'(rs2_data_out), 64'(e.rs2));
        compare("instret", instret_out, e.instret);
        compare("instret_cnt4", 64'(s_instret), 64'(e.instret4));
        compare("last_we", 64'(last_we_out), 64'(e.we));
        compare("last_rd", 64'(last_rd_out), 64'(e.rd));
        compare("last_wdata", 64'(last_wdata_out), 64'(e.wd));
      end
    end
  end

  function automatic logic [31:0] model_read(input logic [4:0] a, input logic cm,
                                             input logic [4:0] r, input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
    if (cm && r == a) return wd;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] ins_of(input logic [4:0] r);
    logic [31:0] t;
    t = $urandom();
    t[11:7] = r;
    t[6:0]  = 7'h33;
    return t;
  endfunction

  task automatic step(input logic rst, input logic [31:0] ins, input logic [31:0] wd,
                      input logic we, input logic [4:0] a1, input logic [4:0] a2,
                      input logic ck);
    exp_t e;
    logic [4:0] r;
    logic cm;
    @(posedge clk);
    #1;
    reset = rst; instruction_WB_in = ins; wb_data_in = wd;
    RegWEn_WB_in = we; rs1_addr_in = a1; rs2_addr_in = a2;
    r  = ins[11:7];
    cm = we && (r != 5'd0) && !rst;
    e.chk = ck;
    e.rs1 = model_read(a1, cm, r, wd);
    e.rs2 = model_read(a2, cm, r, wd);
    e.instret = m_cnt;
    e.instret4 = m_cnt[3:0];
    e.we = m_we; e.rd = m_rd; e.wd = m_wd;
    q.push_back(e);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_cnt = 64'h0; m_we = 1'b0; m_rd = 5'd0; m_wd = 32'h0;
    end else begin
      if (cm) m_regs[r] = wd;
      if (ins != 32'h0) m_cnt = m_cnt + 64'd1;
      m_we = cm;
      if (cm) begin
        m_rd = r; m_wd = wd;
      end
    end
  endtask

  initial begin
    reset = 1'b1; instruction_WB_in = '0; wb_data_in = '0;
    RegWEn_WB_in = 1'b0; rs1_addr_in = '0; rs2_addr_in = '0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_cnt = '0; m_we = 1'b0; m_rd = '0; m_wd = '0;

    // reset cycle carrying a write that must be dropped (outputs undefined yet)
    step(1'b1, ins_of(5'd5), 32'hDEADBEEF, 1'b1, 5'd5, 5'd5, 1'b0);
    // basic commit; rs1=5 must read 0 after reset
    step(1'b0, ins_of(5'd7), 32'h12345678, 1'b1, 5'd5, 5'd0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd7, 1'b1);
    // same-cycle bypass on both ports
    step(1'b0, ins_of(5'd3), 32'hA5A5A5A5, 1'b1, 5'd3, 5'd3, 1'b1);
    // x0 protection
    step(1'b0, ins_of(5'd0), 32'hFFFFFFFF, 1'b1, 5'd0, 5'd3, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd7, 1'b1);
    // bubbles then store-like non-writing instructions
    repeat (3) step(1'b0, 32'h0, $urandom(), 1'b1, 5'd3, 5'd7, 1'b1);
    repeat (2) step(1'b0, ins_of(5'($urandom_range(1, 31))), $urandom(), 1'b0, 5'd3, 5'd7, 1'b1);
    // back-to-back writes to same rd, bypass shows current data
    step(1'b0, ins_of(5'd9), 32'h11111111, 1'b1, 5'd9, 5'd9, 1'b1);
    step(1'b0, ins_of(5'd9), 32'h22222222, 1'b1, 5'd9, 5'd0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 5'd9, 5'd9, 1'b1);
    // counter wrap on the 4-bit instance: 16 retirements from reset
    step(1'b1, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b1);
    for (int i = 0; i < 16; i++)
      step(1'b0, ins_of(5'($urandom_range(0, 31))), $urandom(), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 5'd1, 5'd2, 1'b1);
    // randomized traffic with occasional mid-stream reset
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ins;
      logic [4:0]  r;
      r   = 5'($urandom_range(0, 7));
      ins = ($urandom_range(0, 5) == 0) ? 32'h0 : ins_of(r);
      step(($urandom_range(0, 49) == 0), ins, $urandom(), 1'($urandom_range(0, 3) != 0),
           ($urandom_range(0, 1) != 0) ? r : 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 7)), 1'b1);
    end
    step(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b1);

    repeat (4) @(posedge clk);
    compare("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
